// File: rtl/ccff_pkg.sv
// Shared state encoding and byte-width constant for the configuration-chain loader.
package ccff_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } ccff_state_e;

   // Bits taken from the next byte: a full byte, or only what the chain still needs.
   function automatic logic [3:0] byte_bits(input int unsigned remaining);
      return (remaining >= BYTE_W) ? 4'(BYTE_W) : 4'(remaining);
   endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// Byte stream into the chain loader: valid/ready handshake carrying one config byte.
interface ccff_loader_if;
   import ccff_pkg::*;

   logic [BYTE_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output s_data, output s_valid, input  s_ready);
   modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/ccff_piso8.sv
// 8-bit parallel-load, MSB-first shift register; load has priority over shift.
module ccff_piso8
   import ccff_pkg::*;
(
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              load,
   input  logic              shift,
   input  logic [BYTE_W-1:0] din,
   output logic              msb
);

   logic [BYTE_W-1:0] sreg_q, sreg_d;

   always_comb begin
      sreg_d = sreg_q;
      if (load) begin
         sreg_d = din;
      end else if (shift) begin
         sreg_d = {sreg_q[BYTE_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         sreg_q <= '0;
      end else begin
         sreg_q <= sreg_d;
      end
   end

   assign msb = sreg_q[BYTE_W-1];

endmodule

// File: rtl/ccff_loader.sv
// Loads CHAIN_LEN bits, MSB first, from a byte stream into a configuration flip-flop chain.
// state | meaning
// IDLE  | no load since reset
// LOAD  | waiting for the next byte (s_ready=1)
// SHIFT | streaming bits of the current byte into the chain head
// DONE  | chain holds exactly CHAIN_LEN new bits
module ccff_loader
   import ccff_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 6
) (
   input  logic         prog_clk,
   input  logic         prog_reset_n,
   input  logic         start,
   ccff_loader_if.slave s_if,
   output logic         ccff_head,
   output logic         ccff_shift_en,
   input  logic         ccff_tail,
   output logic         busy,
   output logic         done,
   output logic         tail_parity
);

   localparam int unsigned CW = $clog2(CHAIN_LEN + 1);

   ccff_state_e       state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [3:0]        bits_q, bits_d;
   logic              parity_q, parity_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              ready_q, ready_d;
   logic              shift_en_q, shift_en_d;
   logic              piso_load, piso_shift, piso_msb;
   logic [BYTE_W-1:0] piso_din;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bits_d     = bits_q;
      parity_d   = parity_q;
      done_d     = done_q;
      piso_load  = 1'b0;
      piso_shift = 1'b0;
      piso_din   = s_if.s_data;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = LOAD;
               cnt_d    = CW'(CHAIN_LEN);
               parity_d = 1'b0;
               done_d   = 1'b0;
            end
         end
         LOAD: begin
            if (s_if.s_valid && ready_q) begin
               piso_load = 1'b1;
               bits_d    = byte_bits(32'(cnt_q));
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            piso_shift = 1'b1;
            parity_d   = parity_q ^ ccff_tail;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end
            bits_d = bits_q - 4'd1;
            // Clearing the byte register at the end of each byte keeps ccff_head low outside SHIFT.
            if (bits_q <= 4'd1) begin
               piso_load = 1'b1;
               piso_din  = '0;
               if (cnt_q <= CW'(1)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d    = (state_d == LOAD);
      busy_d     = (state_d == LOAD) || (state_d == SHIFT);
      shift_en_d = (state_d == SHIFT);
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bits_q     <= '0;
         parity_q   <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         shift_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bits_q     <= bits_d;
         parity_q   <= parity_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         shift_en_q <= shift_en_d;
      end
   end

   ccff_piso8 u_piso (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .load         (piso_load),
      .shift        (piso_shift),
      .din          (piso_din),
      .msb          (piso_msb)
   );

   assign s_if.s_ready  = ready_q;
   assign ccff_head     = piso_msb;
   assign ccff_shift_en = shift_en_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign tail_parity   = parity_q;

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 6, meaning the number of configuration flip-flops in the downstream chain (minimum 1).
REQ-002 SHALL have port prog_clk  input  1  programming clock, shared with the configuration chain.
REQ-003 SHALL have port prog_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a chain load.
REQ-005 SHALL have port s_data  input  8  configuration byte, sent MSB first.
REQ-006 SHALL have port s_valid  input  1  s_data is valid.
REQ-007 SHALL have port s_ready  output  1  loader accepts s_data this cycle.
REQ-008 SHALL have port ccff_head  output  1  serial bit into the chain head.
REQ-009 SHALL have port ccff_shift_en  output  1  enable for the external prog_clk gate; the chain shifts on each prog_clk edge where this is 1.
REQ-010 SHALL have port ccff_tail  input  1  serial bit from the chain tail.
REQ-011 SHALL have port busy  output  1  a load is in progress.
REQ-012 SHALL have port done  output  1  the chain holds exactly CHAIN_LEN new bits.
REQ-013 SHALL have port tail_parity  output  1  XOR of all ccff_tail values shifted out during the current or last load.

Function
REQ-014 SHALL use FSM states IDLE, LOAD, SHIFT and DONE.
REQ-015 IDLE or DONE plus start=1 SHALL go to LOAD and clear the remaining-bit counter to CHAIN_LEN, tail_parity to 0 and done to 0.
REQ-016 start SHALL be ignored in LOAD and SHIFT.
REQ-017 s_ready SHALL be 1 only in LOAD.
REQ-018 A byte SHALL be accepted when s_valid and s_ready are both 1; the FSM then enters SHIFT on the next cycle.
REQ-019 s_valid without s_ready SHALL have no effect; the data is not consumed.
REQ-020 SHIFT SHALL output min(8, remaining) bits, one per cycle, MSB first, on registered ccff_head, with ccff_shift_en=1 in the same cycles.
REQ-021 Bits of a partial final byte below the used MSBs SHALL be discarded.
REQ-022 ccff_shift_en SHALL be 0 in every state except SHIFT.
REQ-023 The counter SHALL decrement once per shifted bit and SHALL never wrap below 0.
REQ-024 On each cycle with ccff_shift_en=1, tail_parity SHALL XOR in the ccff_tail value present in that cycle.
REQ-025 At the end of a byte, the FSM SHALL go to DONE if remaining=0, otherwise back to LOAD.
REQ-026 In DONE, done SHALL be 1 and s_ready 0; extra bytes stay unaccepted.
REQ-027 busy SHALL be 1 in LOAD and SHIFT.
REQ-028 The counter width SHALL be clog2(CHAIN_LEN+1).
REQ-029 A full load SHALL take exactly CHAIN_LEN shift-enabled cycles.

Reset
REQ-030 prog_reset_n=0 SHALL asynchronously force IDLE, s_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, tail_parity=0, counter=0 and the byte register to 0.
REQ-031 Reset in the middle of a load SHALL stop shifting immediately; no partial-load done SHALL ever assert.
REQ-032 Release of reset SHALL be synchronous to prog_clk; the first start is honoured on the first clock after release.

Structure
REQ-033 The FSM state encoding and the byte width constant (8) SHALL live in a shared package, ccff_pkg.
REQ-034 The block SHALL contain one sub-module, ccff_piso8: an 8-bit parallel-load, MSB-first shift register with load and shift inputs.
REQ-035 Clock gating SHALL be external; the loader SHALL NOT drive prog_clk.

Verification
REQ-036 CHAIN_LEN=6, start, byte 0xA5 -> ccff_head 1,0,1,0,0,1 over 6 shift_en cycles, then done=1, busy=0.
REQ-037 CHAIN_LEN=20, bytes 0xFF, 0x00, 0xF0 -> 20 shift cycles (8+8+4), ccff_head ends 1,1,1,1, s_ready high exactly 3 times, then done.
REQ-038 CHAIN_LEN=6, chain preloaded 6'b111000 with ccff_tail modelled -> tail_parity=1 after the load.
REQ-039 prog_reset_n low during the 3rd shift cycle -> ccff_shift_en=0 immediately, state IDLE, done=0; a new start reloads correctly.
REQ-040 s_valid held high after done, and start during SHIFT -> no byte accepted, no extra shift, no restart.
REQ-041 s_valid toggling 0/1 every cycle in LOAD -> bytes accepted only when both are high, and the bitstream is identical to the back-to-back case.
